// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage; EX/MEM results to MEM/WB, single-beat bus loads/stores with stall_request; MEM_ALIGN_CHECK_EN adds misalignment trapping via address_error
module mem_access_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_register_write_enable,
  input  logic [4:0]  ex_register_write_address,
  input  logic [31:0] ex_register_write_data,
  input  logic        ex_register_hi_write_enable,
  input  logic [31:0] ex_register_hi_write_data,
  input  logic        ex_register_lo_write_enable,
  input  logic [31:0] ex_register_lo_write_data,
  input  logic [3:0]  ex_memory_operation,
  input  logic [31:0] ex_memory_address,
  input  logic [31:0] ex_memory_store_data,
  output logic        mem_register_write_enable,
  output logic [4:0]  mem_register_write_address,
  output logic [31:0] mem_register_write_data,
  output logic        mem_register_hi_write_enable,
  output logic [31:0] mem_register_hi_write_data,
  output logic        mem_register_lo_write_enable,
  output logic [31:0] mem_register_lo_write_data,
  output logic        stall_request,
  output logic        address_error,
  output logic        bus_request,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_select,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
  localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_next;
  logic        is_load, is_store, is_byte, is_half, misaligned, start, gate;
  logic [1:0]  lane;
  logic [3:0]  select;
  logic [31:0] store_data, byte_shift, half_shift, extended, load_data;
  always_comb begin
    lane       = ex_memory_address[1:0];
    is_load    = ex_memory_operation >= OP_LB && ex_memory_operation <= OP_LW;
    is_store   = ex_memory_operation >= OP_SB && ex_memory_operation <= OP_SW;
    is_byte    = ex_memory_operation == OP_LB || ex_memory_operation == OP_LBU || ex_memory_operation == OP_SB;
    is_half    = ex_memory_operation == OP_LH || ex_memory_operation == OP_LHU || ex_memory_operation == OP_SH;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (is_half && lane[0]) || ((ex_memory_operation == OP_LW || ex_memory_operation == OP_SW) && lane != 2'b00);
`else
    misaligned = 1'b0;
`endif
    select     = is_byte ? 4'b1000 >> lane : is_half ? (lane[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    store_data = is_byte ? {4{ex_memory_store_data[7:0]}} : is_half ? {2{ex_memory_store_data[15:0]}} : ex_memory_store_data;
    byte_shift = bus_read_data >> {~lane, 3'b000};
    half_shift = bus_read_data >> {~lane[1], 4'b0000};
    extended   = ex_memory_operation == OP_LB  ? {{24{byte_shift[7]}}, byte_shift[7:0]} :
                 ex_memory_operation == OP_LBU ? {24'd0, byte_shift[7:0]} :
                 ex_memory_operation == OP_LH  ? {{16{half_shift[15]}}, half_shift[15:0]} :
                 ex_memory_operation == OP_LHU ? {16'd0, half_shift[15:0]} : bus_read_data;
    start         = state == IDLE && (is_load || is_store) && !misaligned;
    stall_request = start || state == ACCESS;
    address_error = state == IDLE && misaligned;
    state_next    = start ? ACCESS : state == ACCESS ? (bus_ack ? DONE : ACCESS) : IDLE;
    gate                         = stall_request || address_error;
    mem_register_write_enable    = ex_register_write_enable && !gate;
    mem_register_hi_write_enable = ex_register_hi_write_enable && !gate;
    mem_register_lo_write_enable = ex_register_lo_write_enable && !gate;
    mem_register_write_address   = ex_register_write_address;
    mem_register_write_data      = state == DONE && is_load ? load_data : ex_register_write_data;
    mem_register_hi_write_data   = ex_register_hi_write_data;
    mem_register_lo_write_data   = ex_register_lo_write_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      bus_request      <= 1'b0;
      bus_write_enable <= 1'b0;
      bus_address      <= 32'd0;
      bus_select       <= 4'd0;
      bus_write_data   <= 32'd0;
      load_data        <= 32'd0;
    end else begin
      state <= state_next;
      if (start) begin
        bus_request      <= 1'b1;
        bus_write_enable <= is_store;
        bus_address      <= {ex_memory_address[31:2], 2'b00};
        bus_select       <= select;
        bus_write_data   <= store_data;
      end else if (state == ACCESS && bus_ack) begin
        bus_request <= 1'b0;
        load_data   <= extended;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed plus randomized checks of mem_access_stage against a lane/extension model
module tb_mem_access_stage;
  logic clock = 1'b0, reset = 1'b1;
  logic ex_register_write_enable = 1'b0, ex_register_hi_write_enable = 1'b0, ex_register_lo_write_enable = 1'b0;
  logic [4:0] ex_register_write_address = 5'd0;
  logic [31:0] ex_register_write_data = 32'd0, ex_register_hi_write_data = 32'd0, ex_register_lo_write_data = 32'd0;
  logic [3:0] ex_memory_operation = 4'd0;
  logic [31:0] ex_memory_address = 32'd0, ex_memory_store_data = 32'd0, bus_read_data = 32'd0;
  logic bus_ack = 1'b0;
  logic mem_register_write_enable, mem_register_hi_write_enable, mem_register_lo_write_enable;
  logic [4:0] mem_register_write_address;
  logic [31:0] mem_register_write_data, mem_register_hi_write_data, mem_register_lo_write_data;
  logic stall_request, address_error, bus_request, bus_write_enable;
  logic [31:0] bus_address, bus_write_data;
  logic [3:0] bus_select;
  int n_cmp = 0, n_err = 0;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .ex_register_write_enable(ex_register_write_enable), .ex_register_write_address(ex_register_write_address),
    .ex_register_write_data(ex_register_write_data),
    .ex_register_hi_write_enable(ex_register_hi_write_enable), .ex_register_hi_write_data(ex_register_hi_write_data),
    .ex_register_lo_write_enable(ex_register_lo_write_enable), .ex_register_lo_write_data(ex_register_lo_write_data),
    .ex_memory_operation(ex_memory_operation), .ex_memory_address(ex_memory_address),
    .ex_memory_store_data(ex_memory_store_data),
    .mem_register_write_enable(mem_register_write_enable), .mem_register_write_address(mem_register_write_address),
    .mem_register_write_data(mem_register_write_data),
    .mem_register_hi_write_enable(mem_register_hi_write_enable), .mem_register_hi_write_data(mem_register_hi_write_data),
    .mem_register_lo_write_enable(mem_register_lo_write_enable), .mem_register_lo_write_data(mem_register_lo_write_data),
    .stall_request(stall_request), .address_error(address_error),
    .bus_request(bus_request), .bus_write_enable(bus_write_enable), .bus_address(bus_address),
    .bus_select(bus_select), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [3:0] op);
    return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
  endfunction

  function automatic int m_first(input logic [3:0] op, input logic [31:0] a);
    int s = m_size(op);
    return s == 4 ? 0 : s == 2 ? int'(a % 4) / 2 * 2 : int'(a % 4);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] r = 4'd0;
    for (int k = 0; k < 4; k++)
      if (k >= m_first(op, a) && k < m_first(op, a) + m_size(op)) r[3-k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    int s = m_size(op);
    return s == 1 ? (d & 32'hFF) * 32'h01010101 : s == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    int s = m_size(op);
    logic [31:0] v = d >> (8 * (4 - m_first(op, a) - s));
    if (s == 1) v = v & 32'hFF;
    if (s == 2) v = v & 32'hFFFF;
    if (op == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
    if (op == 3 && v >= 32'h8000) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (m_size(op) == 2 && a % 2 != 0) || (m_size(op) == 4 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd, input logic we);
    ex_memory_operation = op;
    ex_memory_address = a;
    ex_memory_store_data = sd;
    ex_register_write_enable = we;
    ex_register_write_address = 5'($urandom);
    ex_register_write_data = $urandom;
    ex_register_hi_write_enable = 1'b1;
    ex_register_lo_write_enable = 1'b1;
    ex_register_hi_write_data = $urandom;
    ex_register_lo_write_data = $urandom;
  endtask

  task automatic mem_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int waits, input logic we);
    int stalls = 0;
    logic ld = op >= 1 && op <= 5;
    drive(op, a, sd, we);
    bus_ack = 1'($urandom);
    #1;
    chk("idle_stall", stall_request, 1);
    chk("idle_we", mem_register_write_enable, 0);
    chk("idle_hi_we", mem_register_hi_write_enable, 0);
    chk("idle_breq", bus_request, 0);
    stalls++;
    @(posedge clock); #1;
    bus_ack = 1'b0;
    chk("acc_breq", bus_request, 1);
    chk("acc_bwe", bus_write_enable, ld ? 0 : 1);
    chk("acc_addr", bus_address, a & ~32'd3);
    chk("acc_sel", bus_select, m_sel(op, a));
    chk("acc_wdata", bus_write_data, m_wdata(op, sd));
    for (int i = 0; i < waits; i++) begin
      chk("wait_stall", stall_request, 1);
      chk("wait_we", mem_register_write_enable, 0);
      stalls++;
      @(posedge clock); #1;
      chk("wait_breq", bus_request, 1);
    end
    chk("ack_stall", stall_request, 1);
    stalls++;
    bus_read_data = rd;
    bus_ack = 1'b1;
    @(posedge clock); #1;
    bus_ack = 1'($urandom);
    bus_read_data = $urandom;
    chk("stall_cycles", stalls, waits + 2);
    chk("done_stall", stall_request, 0);
    chk("done_breq", bus_request, 0);
    chk("done_we", mem_register_write_enable, we);
    chk("done_hi_we", mem_register_hi_write_enable, 1);
    chk("done_data", mem_register_write_data, ld ? m_load(op, a, rd) : ex_register_write_data);
    chk("done_lo", mem_register_lo_write_data, ex_register_lo_write_data);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clock); #1;
    bus_ack = 1'b0;
    chk("gap_breq", bus_request, 0);
    chk("gap_stall", stall_request, 0);
  endtask

  task automatic mis_op(input logic [3:0] op, input logic [31:0] a);
    drive(op, a, $urandom, 1'b1);
    #1;
    chk("mis_err", address_error, 1);
    chk("mis_stall", stall_request, 0);
    chk("mis_we", mem_register_write_enable, 0);
    chk("mis_hi_we", mem_register_hi_write_enable, 0);
    @(posedge clock); #1;
    chk("mis_breq", bus_request, 0);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_breq", bus_request, 0);
    chk("rst_bwe", bus_write_enable, 0);
    chk("rst_addr", bus_address, 0);
    chk("rst_sel", bus_select, 0);
    chk("rst_wdata", bus_write_data, 0);
    chk("rst_aerr", address_error, 0);
    reset = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b1);
    ex_register_write_address = 5'd3;
    ex_register_write_data = 32'h12345678;
    #1;
    chk("add_we", mem_register_write_enable, 1);
    chk("add_addr", mem_register_write_address, 3);
    chk("add_data", mem_register_write_data, 32'h12345678);
    chk("add_stall", stall_request, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("add_breq", bus_request, 0);
    end
    ex_memory_operation = 4'd12;
    bus_ack = 1'b1;
    #1;
    chk("nop12_stall", stall_request, 0);
    chk("nop12_we", mem_register_write_enable, 1);
    @(posedge clock); #1;
    bus_ack = 1'b0;
    chk("nop12_breq", bus_request, 0);
    mem_op(4'd1, 32'h103, 32'd0, 32'h000000F0, 2, 1'b1);
    mem_op(4'd4, 32'h102, 32'd0, 32'h0000ABCD, 0, 1'b1);
    mem_op(4'd7, 32'h200, 32'h00001234, 32'd0, 1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    mis_op(4'd5, 32'h102);
`else
    mem_op(4'd5, 32'h102, 32'd0, 32'hCAFEF00D, 0, 1'b1);
`endif
    drive(4'd5, 32'h40, 32'd0, 1'b1);
    #1;
    @(posedge clock); #1;
    chk("mid_breq_before", bus_request, 1);
    reset = 1'b1;
    bus_ack = 1'b1;
    bus_read_data = 32'hDEADBEEF;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus_ack = 1'b0;
    chk("mid_breq", bus_request, 0);
    chk("mid_stall", stall_request, 0);
    chk("mid_we", mem_register_write_enable, 0);
    @(posedge clock); #1;
    chk("mid_breq2", bus_request, 0);
    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      if (m_mis(op, a)) mis_op(op, a);
      else mem_op(op, a, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM and MEM/WB latches. Non-memory results pass straight through to the MEM/WB latch. Loads and stores run a single-beat bus transaction through a small state machine that requests a pipeline stall until the bus acknowledges. Loaded bytes and halfwords are lane-selected and sign/zero-extended before writeback.

## Interface
- No parameters.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ex_register_write_enable  in  1  GPR write enable from EX/MEM latch
- ex_register_write_address  in  5  GPR destination
- ex_register_write_data  in  32  ALU result (non-load data)
- ex_register_hi_write_enable / ex_register_lo_write_enable  in  1  HI/LO write enables
- ex_register_hi_write_data / ex_register_lo_write_data  in  32  HI/LO data
- ex_memory_operation  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
- ex_memory_address  in  32  effective address
- ex_memory_store_data  in  32  rt value for stores
- mem_register_write_enable, mem_register_write_address, mem_register_write_data, mem_register_hi_write_enable, mem_register_hi_write_data, mem_register_lo_write_enable, mem_register_lo_write_data  out  1/5/32/1/32/1/32  to MEM/WB latch
- stall_request  out  1  hold EX/MEM latch and upstream stages
- address_error  out  1  misaligned access flag
- bus_request  out  1  transaction valid (registered)
- bus_write_enable  out  1  1 store, 0 load (registered)
- bus_address  out  32  {address[31:2], 2'b00} (registered)
- bus_select  out  4  byte lanes, bit 3 = bits 31:24 (registered)
- bus_write_data  out  32  store data replicated across lanes (registered)
- bus_read_data  in  32  load data, valid with bus_ack
- bus_ack  in  1  single-cycle completion

## Operation
- Big-endian lanes: address[1:0]=0 selects bits 31:24. Byte select 1000/0100/0010/0001; halfword 1100 (addr[1]=0) / 0011 (addr[1]=1); word 1111.
- Store data: SB {4{b}}, SH {2{h}}, SW word.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW as is.
- FSM states IDLE, ACCESS, DONE.
- IDLE: memory op present -> stall_request=1 combinationally; register bus_request=1, write_enable, address, select, write_data; next ACCESS. NOP -> pass-through, stall 0.
- ACCESS: stall_request=1, bus outputs held. bus_ack=1 -> capture extended read data, drop bus_request at that edge, next DONE. No ack -> stay (no timeout).
- DONE: stall_request=0; outputs reflect EX inputs, with write data = captured load data for loads; next IDLE unconditionally.
- stall_request=1 forces all three mem_* write enables to 0 (bubble into WB); address/data still driven.
- bus_ack outside ACCESS is ignored.

## Timing
- Reset: state IDLE, bus_request 0, bus_write_enable 0, bus_address 0, bus_select 0, bus_write_data 0, captured data 0. Combinational outputs follow inputs; address_error 0.
- Non-memory op: 0-cycle latency, no stall.
- Memory op: 3 cycles minimum (IDLE, ACCESS with ack, DONE); each ack wait cycle adds 1.
- Back-to-back memory ops: DONE -> IDLE, then the next op starts; bus_request low for at least one cycle between transactions.
- Reset mid-ACCESS: state IDLE and bus_request 0 after the reset edge; in-flight load data discarded; stall drops after that edge.
- EX inputs stay stable while stall_request=1; the upstream latch guarantees this.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with address[0]=1, or LW/SW with address[1:0]≠0, stay in IDLE, issue no bus transaction and no stall; address_error=1 combinationally and all mem_* write enables 0 that cycle.
- Undefined: address_error tied 0. Halfwords use address[1] only; words ignore address[1:0].

## Test plan
- ADD result 0x12345678 to r3, NOP memory op -> same-cycle mem outputs write r3 = 0x12345678, stall_request 0, bus_request never 1.
- LB address 0x103, bus_read_data 0x000000F0, ack after 2 wait cycles -> bus_select 0001, bus_address 0x100, stall high 4 cycles, then write data 0xFFFFFFF0 with enable 1.
- LHU address 0x102, data 0x0000ABCD, immediate ack -> 3-cycle sequence, write data 0x0000ABCD.
- SH address 0x200, store data 0x00001234 -> bus_write_enable 1, select 1100, write_data 0x12341234; GPR enable 0 throughout.
- Reset asserted while in ACCESS -> bus_request 0 after the edge, state IDLE, no GPR write.
- With MEM_ALIGN_CHECK_EN: LW address 0x102 -> address_error 1, no bus_request, no stall, enables 0. Without the macro: bus_address 0x100, select 1111.
